// File: rtl/logit_approx_seq_if.sv
// Handshake bundle for logit_approx_seq: input y channel and output x channel.
// The slave modport is the converter's side of both channels.
interface logit_approx_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/logit_approx_seq.sv
// Q8.8 probability -> signed Q8.8 logit, piecewise-linear log2, iterative normalise.
// Define LOGIT_FAST_NORM_EN for single-cycle normalisation via priority encoder.
module logit_approx_seq #(
  parameter logic [15:0] SAT_POS = 16'h7FFF,
  parameter logic [15:0] SAT_NEG = 16'h8000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  logit_approx_seq_if.slave bus,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t      state_q;
  logic [8:0]  t_q;
  logic [2:0]  n_q;
  logic        side_q;
  logic        out_valid_q;
  logic [15:0] out_data_q;

  logic        sat_neg_d;
  logic        sat_pos_d;
  logic        side_acc_d;
  logic [8:0]  t_acc_d;
  logic [8:0]  t_fin_d;
  logic [2:0]  n_fin_d;
  logic        norm_done_d;
  logic [6:0]  m_d;
  logic [15:0] mag_d;
  logic [15:0] res_d;

  assign bus.in_ready  = ena & (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != IDLE);

  assign sat_neg_d  = bus.in_data[15] | (bus.in_data == 16'h0000);
  assign sat_pos_d  = (bus.in_data >= 16'h0100);
  // y < 1.0 here, so y >= 0.5 is just bit 7
  assign side_acc_d = bus.in_data[7];
  assign t_acc_d    = side_acc_d ? (9'h100 - bus.in_data[8:0])
                                 : bus.in_data[8:0];

`ifdef LOGIT_FAST_NORM_EN
  logic [2:0] s_d;

  always_comb begin
    s_d = 3'd0;
    priority case (1'b1)
      t_q[8], t_q[7], t_q[6]: s_d = 3'd0;
      t_q[5]: s_d = 3'd1;
      t_q[4]: s_d = 3'd2;
      t_q[3]: s_d = 3'd3;
      t_q[2]: s_d = 3'd4;
      t_q[1]: s_d = 3'd5;
      t_q[0]: s_d = 3'd6;
      default: s_d = 3'd0;
    endcase
  end

  assign t_fin_d     = t_q << s_d;
  assign n_fin_d     = s_d;
  assign norm_done_d = 1'b1;
`else
  assign t_fin_d     = t_q;
  assign n_fin_d     = n_q;
  assign norm_done_d = (t_q >= 9'd64);
`endif

  // t is in [64,128] here, so m fits in 7 bits
  assign m_d   = 7'(9'd128 - t_fin_d);
  assign mag_d = {5'b0, n_fin_d, 8'b0}
               + {7'b0, m_d, 2'b0};
  assign res_d = side_q ? mag_d
                        : (~mag_d + 16'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      n_q         <= '0;
      side_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (sat_neg_d) begin
              out_data_q  <= SAT_NEG;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else if (sat_pos_d) begin
              out_data_q  <= SAT_POS;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              side_q  <= side_acc_d;
              t_q     <= t_acc_d;
              n_q     <= 3'd0;
              state_q <= NORM;
            end
          end
        end
        NORM: begin
          if (norm_done_d) begin
            t_q         <= t_fin_d;
            n_q         <= n_fin_d;
            out_data_q  <= res_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            t_q <= t_q << 1;
            n_q <= n_q + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logit_approx_seq.sv
// Directed bench for logit_approx_seq: vectors, saturation, backpressure,
// enable stall, mid-conversion reset and a monotonic sweep against a model.
module tb_logit_approx_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic busy;

  logit_approx_seq_if bus ();

  logit_approx_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

`ifdef LOGIT_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int s, input bit sat);
    if (sat) return 0;
    return FAST ? 1 : 1 + s;
  endfunction

  task automatic model(input logic [15:0] y,
                       output logic [15:0] x,
                       output int s,
                       output bit sat);
    int t;
    int mag;
    s = 0;
    sat = 1'b1;
    if (y[15] || y == 16'h0000) begin
      x = 16'h8000;
    end else if (y >= 16'h0100) begin
      x = 16'h7FFF;
    end else begin
      sat = 1'b0;
      t = (y >= 16'h0080) ? 256 - int'(y) : int'(y);
      while (t < 64) begin
        t = t * 2;
        s++;
      end
      mag = s * 256 + (128 - t) * 4;
      x = (y >= 16'h0080) ? 16'(mag) : 16'(-mag);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [15:0] y,
                     input logic [15:0] exp,
                     input int lat_exp);
    int lat;
    @(negedge clk);
    check({tag, "/rdy"}, 32'(bus.in_ready), 32'd1);
    bus.in_data   = y;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check({tag, "/lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "/data"}, 32'(bus.out_data), 32'(exp));
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "/vclr"}, 32'(bus.out_valid), 32'd0);
    check({tag, "/idle"}, 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int cnt;
    logic [15:0] x;
    logic [15:0] prev;
    int s;
    bit sat;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/valid", 32'(bus.out_valid), 32'd0);
    check("rst/data", 32'(bus.out_data), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/rdy", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;

    run("y80", 16'h0080, 16'h0000, lat_of(0, 0));
    run("yC0", 16'h00C0, 16'h0100, lat_of(0, 0));
    run("y40", 16'h0040, 16'hFF00, lat_of(0, 0));
    run("y41", 16'h0041, 16'hFF04, lat_of(0, 0));
    run("y01", 16'h0001, 16'hF900, lat_of(6, 0));
    run("yFF", 16'h00FF, 16'h0700, lat_of(6, 0));
    run("y20", 16'h0020, 16'hFE00, lat_of(1, 0));
    run("s0000", 16'h0000, 16'h8000, lat_of(0, 1));
    run("s8123", 16'h8123, 16'h8000, lat_of(0, 1));
    run("s0100", 16'h0100, 16'h7FFF, lat_of(0, 1));
    run("s0200", 16'h0200, 16'h7FFF, lat_of(0, 1));

    // backpressure
    @(negedge clk);
    bus.in_data   = 16'h00C0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    check("bp/lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp/valid", 32'(bus.out_valid), 32'd1);
      check("bp/data", 32'(bus.out_data), 32'h0100);
      check("bp/rdy", 32'(bus.in_ready), 32'd0);
      bus.in_data  = 16'(16'h0010 + i);
      bus.in_valid = 1'b1;
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp/vclr", 32'(bus.out_valid), 32'd0);
    check("bp/hold", 32'(bus.out_data), 32'h0100);
    check("bp/idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("bp/once", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // enable stall during normalisation
    bus.in_data  = 16'h0001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    ena = 1'b0;
    check("ena/rdy", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("ena/valid", 32'(bus.out_valid), 32'd0);
    ena = 1'b1;
    wait_valid(lat);
    check("ena/lat", 32'(3 + lat), 32'(lat_of(6, 0) + 3));
    check("ena/data", 32'(bus.out_data), 32'hF900);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // reset aborts a conversion
    bus.in_data  = 16'h0001;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rstm/valid", 32'(bus.out_valid), 32'd0);
    check("rstm/busy", 32'(busy), 32'd0);
    check("rstm/data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) cnt++;
    end
    check("rstm/none", 32'(cnt), 32'd0);
    check("rstm/rdy", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;

    // sweep
    prev = 16'h8000;
    for (int y = 0; y <= 256; y++) begin
      model(16'(y), x, s, sat);
      run("sweep", 16'(y), x, lat_of(s, sat));
      check("mono", 32'($signed(bus.out_data) >= $signed(prev)), 32'd1);
      prev = bus.out_data;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
